matmul_engine: RTL and testbench
================================

// Module: matmul_engine
// PURPOSE
//  Computes R = A x B (unsigned) from matrix memories A and B and writes each element into matrix memory R.
//  Sits directly upstream of the R-matrix UART transmit stage. done is a held level that drives that stage's read_R_mat input.
//  One MAC is shared sequentially; there is one A read and one B read per inner-product term.
// PARAMETERS
//  M        2   rows of A and R
//  K        2   cols of A = rows of B (inner dimension), >=1
//  N        2   cols of B and R
//  DATA_W   8   element width of A, B and R (R byte feeds the UART)
//  ADDR_W   6   memory address width; M*K, K*N and M*N must each be <= 2**ADDR_W
//  ACC_W    2*DATA_W+$clog2(K+1)   accumulator width, so no internal overflow occurs
// PORTS
//  clk       in   1       single clock domain, all logic on rising edge
//  rst       in   1       synchronous, active-low reset (asserted when 0)
//  start     in   1       start request, sampled only in IDLE
//  busy      out  1       high while computing
//  done      out  1       set after the last R write; held until the next accepted start or reset
//  a_read    out  1       read strobe to memory A
//  a_addr    out  ADDR_W  A address, row-major: i*K+k
//  a_data    in   DATA_W  A read data, valid the cycle after a_read
//  b_read    out  1       read strobe to memory B
//  b_addr    out  ADDR_W  B address, row-major: k*N+j
//  b_data    in   DATA_W  B read data, valid the cycle after b_read
//  r_write   out  1       write strobe to memory R, one cycle per element
//  r_addr    out  ADDR_W  R address, row-major: i*N+j
//  r_wdata   out  DATA_W  R element value
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): state=IDLE; i=j=k=0; acc=0.
//    busy, done, a_read, b_read and r_write are all 0; addresses and r_wdata are 0.
//    Memory contents are untouched. Reset mid-run aborts the run with no further writes.
//  - FSM:
//    IDLE  -(start)->                 READ
//    READ  ->                         ACC
//    ACC   -(k<K-1)->                 READ
//    ACC   -(k==K-1)->                WRITE
//    WRITE -(not last element)->      READ
//    WRITE -(last element)->          IDLE
//  - IDLE: busy=0. On start: clear done; i=j=k=0; acc=0.
//  - READ: a_read=b_read=1 with a_addr=i*K+k, b_addr=k*N+j.
//  - ACC: acc += a_data*b_data; k++ unless k==K-1.
//  - WRITE: r_write=1, r_addr=i*N+j, r_wdata=fmt(acc). Then acc=0, k=0, and (i,j) advance row-major (j first, wraps to 0 with i++).
//    The last element is i==M-1 && j==N-1; done is set on that exit edge.
//  - Strobes are registered: high for exactly the one cycle the FSM is in READ/WRITE.
//  - Latency: done is first high M*N*(2K+1) clocks after the edge that samples start (20 for 2x2x2). busy is high for exactly those cycles.
//  - start while busy is ignored. start held high after completion starts a new run on the next IDLE edge.
//  - fmt(acc) default: truncate to the low DATA_W bits.
// CONFIGURATION
//  MATMUL_SATURATE_EN:
//    defined     fmt(acc) = (acc > 2**DATA_W-1) ? all-ones : acc[DATA_W-1:0]
//    undefined   fmt(acc) = acc[DATA_W-1:0] (wrap)
//  Timing and handshake are identical either way.
// STRUCTURE
//  - Shared package matmul_pkg: FSM state encoding (IDLE/READ/ACC/WRITE) and the default M/K/N/DATA_W/ADDR_W constants.
//    The same constants are shared with the memory and TX-stage instances.
//  - One sub-module, matmul_mac: the accumulator register with clear, multiply-add enable and fmt output (saturation gated by MATMUL_SATURATE_EN).
//  - Address generation and the index counters stay in matmul_engine.
// TESTING
//  1. A=[1 2;3 4], B=[5 6;7 8], pulse start
//     -> writes R[0..3]=19,22,43,50 in that order; done high 20 clocks after start; busy low.
//  2. A=I, B=[9 8;7 6] -> R=9,8,7,6. Check a_addr sequence 0,1,0,1,2,3,2,3 and b_addr sequence 0,2,1,3,0,2,1,3.
//  3. A,B all 0xFF -> acc=130050 (0x1FC02) per element.
//     -> R=0x02 without MATMUL_SATURATE_EN; R=0xFF with it defined.
//  4. start re-pulsed at cycles 3 and 10 of a run -> ignored; exactly 4 r_write pulses; done timing unchanged.
//  5. rst=0 in the cycle after the 2nd r_write -> no further writes; all outputs 0.
//     Next start gives correct R from scratch.
//  6. Two back-to-back runs with start held high
//     -> done drops on the restart edge; second result correct; 8 r_write pulses total.

Source files
------------

// File: rtl/matmul_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matrix-multiply engine and its neighbours (the
// A/B/R memories and the R-matrix UART transmit stage use the same default
// dimension constants).
//   state_t        FSM state encoding: IDLE / READ / ACC / WRITE
//   DEF_*          default M, K, N, DATA_W and ADDR_W
//   acc_width()    accumulator width that can hold K full-scale products
// ---------------------------------------------------------------------------
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_ACC   = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam int DEF_M      = 2;
  localparam int DEF_K      = 2;
  localparam int DEF_N      = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;

  // Sum of K products of two DATA_W-bit values never exceeds this width.
  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + $clog2(k + 1);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// ---------------------------------------------------------------------------
// matmul_mac
// Shared multiply-accumulate unit for the matrix-multiply engine.
// Build option: MATMUL_SATURATE_EN
//   defined   -> o_fmt_next saturates to all-ones when the sum exceeds DATA_W bits
//   undefined -> o_fmt_next is the low DATA_W bits of the sum (wraps)
// Ports
//   clk         in   1       rising-edge clock
//   rst         in   1       synchronous reset, active low (clears accumulator)
//   i_clr       in   1       clear accumulator to 0 (wins over i_en)
//   i_en        in   1       accumulate i_a*i_b on this edge
//   i_a, i_b    in   DATA_W  multiplicands
//   o_fmt_next  out  DATA_W  formatted value the accumulator will hold after
//                            this edge (acc + product when i_en), so the engine
//                            can register the R element on the final ACC edge
// ---------------------------------------------------------------------------
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = acc_width(DEF_DATA_W, DEF_K)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_fmt_next
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_prod;
  logic [ACC_W-1:0] w_sum;

  assign w_prod = ACC_W'(i_a) * ACC_W'(i_b);
  assign w_sum  = r_acc + (i_en ? w_prod : '0);

`ifdef MATMUL_SATURATE_EN
  // Any set bit above the element width means the value does not fit.
  assign o_fmt_next = (|w_sum[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
  assign o_fmt_next = w_sum[DATA_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// ---------------------------------------------------------------------------
// matmul_engine
// Computes R = A x B (unsigned) with one shared MAC: each inner-product term
// costs a READ cycle (A and B read strobes) and an ACC cycle (data arrives,
// multiply-add), and each R element costs one WRITE cycle. done is a held
// level that feeds the R-matrix UART transmit stage.
// Build option: MATMUL_SATURATE_EN (R element saturates instead of wrapping;
// handled in matmul_mac, timing unaffected).
// Ports
//   clk       in   1       rising-edge clock
//   rst       in   1       synchronous reset, active low
//   start     in   1       start request, only honoured in IDLE
//   busy      out  1       high while a run is in progress
//   done      out  1       set after the last R write, held until next start
//   a_read    out  1       A read strobe, a_addr = i*K+k (data next cycle)
//   a_addr    out  ADDR_W
//   a_data    in   DATA_W
//   b_read    out  1       B read strobe, b_addr = k*N+j (data next cycle)
//   b_addr    out  ADDR_W
//   b_data    in   DATA_W
//   r_write   out  1       R write strobe, one cycle per element
//   r_addr    out  ADDR_W  i*N+j
//   r_wdata   out  DATA_W  formatted accumulator
// All outputs are registered; strobes are high exactly for the READ/WRITE
// state cycle because they are loaded together with the state register.
// ---------------------------------------------------------------------------
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int M      = DEF_M,
  parameter int K      = DEF_K,
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ACC_W  = acc_width(DATA_W, K)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              a_read,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              b_read,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              r_write,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_wdata
);

  // Dimension constants at address width so index arithmetic stays in ADDR_W.
  localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(M - 1);
  localparam logic [ADDR_W-1:0] J_LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] K_A    = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] N_A    = ADDR_W'(N);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_i, r_j, r_k;
  logic [ADDR_W-1:0] w_i_next, w_j_next, w_k_next;

  logic              r_busy, r_done, r_a_read, r_b_read, r_r_write;
  logic [ADDR_W-1:0] r_a_addr, r_b_addr, r_r_addr;
  logic [DATA_W-1:0] r_r_wdata;

  logic              w_busy_next, w_done_next, w_read_next, w_write_next;
  logic [ADDR_W-1:0] w_a_addr_next, w_b_addr_next, w_r_addr_next;
  logic [DATA_W-1:0] w_r_wdata_next;

  logic              w_mac_clr, w_mac_en;
  logic [DATA_W-1:0] w_fmt_next;

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_mac_clr),
    .i_en       (w_mac_en),
    .i_a        (a_data),
    .i_b        (b_data),
    .o_fmt_next (w_fmt_next)
  );

  always_comb begin
    w_state_next   = r_state;
    w_i_next       = r_i;
    w_j_next       = r_j;
    w_k_next       = r_k;
    w_done_next    = r_done;
    w_read_next    = 1'b0;
    w_write_next   = 1'b0;
    w_a_addr_next  = r_a_addr;
    w_b_addr_next  = r_b_addr;
    w_r_addr_next  = r_r_addr;
    w_r_wdata_next = r_r_wdata;
    w_mac_clr      = 1'b0;
    w_mac_en       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_READ;
          w_i_next     = '0;
          w_j_next     = '0;
          w_k_next     = '0;
          w_done_next  = 1'b0;
          w_mac_clr    = 1'b1;
          w_read_next  = 1'b1;
        end
      end

      ST_READ: begin
        w_state_next = ST_ACC;
      end

      ST_ACC: begin
        w_mac_en = 1'b1;
        if (r_k != K_LAST) begin
          w_k_next     = r_k + 1'b1;
          w_state_next = ST_READ;
          w_read_next  = 1'b1;
        end else begin
          // Last term: the element value is the sum including this product.
          w_state_next   = ST_WRITE;
          w_write_next   = 1'b1;
          w_r_addr_next  = r_i * N_A + r_j;
          w_r_wdata_next = w_fmt_next;
        end
      end

      ST_WRITE: begin
        w_mac_clr = 1'b1;
        w_k_next  = '0;
        if (r_j == J_LAST) begin
          w_j_next = '0;
          w_i_next = (r_i == I_LAST) ? '0 : r_i + 1'b1;
        end else begin
          w_j_next = r_j + 1'b1;
        end
        if ((r_i == I_LAST) && (r_j == J_LAST)) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_state_next = ST_READ;
          w_read_next  = 1'b1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Read addresses come from the indices the READ cycle will hold.
    if (w_read_next) begin
      w_a_addr_next = w_i_next * K_A + w_k_next;
      w_b_addr_next = w_k_next * N_A + w_j_next;
    end

    w_busy_next = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_a_read  <= 1'b0;
      r_b_read  <= 1'b0;
      r_r_write <= 1'b0;
      r_a_addr  <= '0;
      r_b_addr  <= '0;
      r_r_addr  <= '0;
      r_r_wdata <= '0;
    end else begin
      r_state   <= w_state_next;
      r_i       <= w_i_next;
      r_j       <= w_j_next;
      r_k       <= w_k_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_a_read  <= w_read_next;
      r_b_read  <= w_read_next;
      r_r_write <= w_write_next;
      r_a_addr  <= w_a_addr_next;
      r_b_addr  <= w_b_addr_next;
      r_r_addr  <= w_r_addr_next;
      r_r_wdata <= w_r_wdata_next;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign a_read  = r_a_read;
  assign b_read  = r_b_read;
  assign r_write = r_r_write;
  assign a_addr  = r_a_addr;
  assign b_addr  = r_b_addr;
  assign r_addr  = r_r_addr;
  assign r_wdata = r_r_wdata;

endmodule

// File: tb/tb_matmul_engine.sv
// ---------------------------------------------------------------------------
// tb_matmul_engine
// Self-checking bench for matmul_engine (default 2x2x2, 8-bit). Memories A
// and B are modelled with a one-cycle registered read; every R write is
// logged and compared with a reference product computed from the memory
// contents with plain nested loops.
// ---------------------------------------------------------------------------
module tb_matmul_engine;

  localparam int M  = 2;
  localparam int K  = 2;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int LAT = M * N * (2 * K + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done;
  logic          a_read, b_read, r_write;
  logic [AW-1:0] a_addr, b_addr, r_addr;
  logic [DW-1:0] a_data, b_data, r_wdata;

  always #5 clk = ~clk;

  matmul_engine dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .a_read  (a_read),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_read  (b_read),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .r_write (r_write),
    .r_addr  (r_addr),
    .r_wdata (r_wdata)
  );

  logic [DW-1:0] mem_a [0:63];
  logic [DW-1:0] mem_b [0:63];

  always @(posedge clk) begin
    if (a_read) a_data <= mem_a[a_addr];
    if (b_read) b_data <= mem_b[b_addr];
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Transaction log, sampled mid-cycle.
  int wq_addr[$];
  int wq_data[$];
  int aq[$];
  int bq[$];
  int n_writes = 0;

  always @(negedge clk) begin
    if (r_write) begin
      wq_addr.push_back(int'(r_addr));
      wq_data.push_back(int'(r_wdata));
      n_writes++;
    end
    if (a_read) aq.push_back(int'(a_addr));
    if (b_read) bq.push_back(int'(b_addr));
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int fmt(input longint s);
`ifdef MATMUL_SATURATE_EN
    return (s > 255) ? 255 : int'(s);
`else
    return int'(s % 256);
`endif
  endfunction

  function automatic int ref_elem(input int i, input int j);
    longint s = 0;
    for (int k = 0; k < K; k++) begin
      int unsigned av = mem_a[i * K + k];
      int unsigned bv = mem_b[k * N + j];
      s += longint'(av * bv);
    end
    return fmt(s);
  endfunction

  task automatic load_random();
    for (int x = 0; x < M * K; x++) mem_a[x] = DW'($urandom_range(0, 255));
    for (int x = 0; x < K * N; x++) mem_b[x] = DW'($urandom_range(0, 255));
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    aq.delete();
    bq.delete();
  endtask

  // Every R element, in row-major order, matching the reference product.
  task automatic check_result(input string tag);
    chk({tag, "_nwr"}, wq_addr.size(), M * N);
    for (int e = 0; e < M * N && e < wq_addr.size(); e++) begin
      chk($sformatf("%s_addr%0d", tag, e), wq_addr[e], e);
      chk($sformatf("%s_data%0d", tag, e), wq_data[e], ref_elem(e / N, e % N));
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_rd"},    int'(a_read) + int'(b_read), 0);
    chk({tag, "_wr"},    int'(r_write), 0);
    chk({tag, "_addrs"}, int'(a_addr) + int'(b_addr) + int'(r_addr), 0);
    chk({tag, "_wdata"}, int'(r_wdata), 0);
  endtask

  // Pulse start for one edge; returns the count of the edge that sampled it.
  task automatic pulse_start(output int s_edge);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    s_edge = edge_cnt;
    start = 1'b0;
  endtask

  // Wait for done; optionally re-pulse start at cycles 3 and 10 of the run.
  task automatic wait_done(input string tag, input bit repulse, input int s_edge,
                           input bit chk_busy);
    int busy_cyc = 0;
    bit seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      busy_cyc += int'(busy);
      if (repulse) start = (n == 3 || n == 10);
    end
    start = 1'b0;
    chk({tag, "_seen"}, int'(seen), 1);
    chk({tag, "_lat"}, edge_cnt - s_edge, LAT);
    chk({tag, "_busylow"}, int'(busy), 0);
    if (chk_busy) chk({tag, "_busycyc"}, busy_cyc, LAT);
  endtask

  initial begin
    int s;
    int s2;
    int wbase;
    int wcnt;

    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;
    @(negedge clk);

    // 1: fixed 2x2 product
    mem_a[0] = 8'd1; mem_a[1] = 8'd2; mem_a[2] = 8'd3; mem_a[3] = 8'd4;
    mem_b[0] = 8'd5; mem_b[1] = 8'd6; mem_b[2] = 8'd7; mem_b[3] = 8'd8;
    clear_q();
    pulse_start(s);
    wait_done("t1", 1'b0, s, 1'b1);
    check_result("t1");
    if (wq_data.size() == 4) begin
      chk("t1_r0", wq_data[0], 19);
      chk("t1_r1", wq_data[1], 22);
      chk("t1_r2", wq_data[2], 43);
      chk("t1_r3", wq_data[3], 50);
    end else begin
      chk("t1_count", wq_data.size(), 4);
    end
    $display("t1 fixed product: writes=%0d", wq_data.size());

    // 2: identity times B, with address sequences
    mem_a[0] = 8'd1; mem_a[1] = 8'd0; mem_a[2] = 8'd0; mem_a[3] = 8'd1;
    mem_b[0] = 8'd9; mem_b[1] = 8'd8; mem_b[2] = 8'd7; mem_b[3] = 8'd6;
    clear_q();
    pulse_start(s);
    wait_done("t2", 1'b0, s, 1'b0);
    check_result("t2");
    chk("t2_nreads_a", aq.size(), M * N * K);
    chk("t2_nreads_b", bq.size(), M * N * K);
    begin
      int idx = 0;
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          for (int k = 0; k < K; k++) begin
            if (idx < aq.size()) chk($sformatf("t2_aaddr%0d", idx), aq[idx], i * K + k);
            if (idx < bq.size()) chk($sformatf("t2_baddr%0d", idx), bq[idx], k * N + j);
            idx++;
          end
    end
    $display("t2 identity: a_reads=%0d b_reads=%0d", aq.size(), bq.size());

    // 3: full-scale operands, overflow of the element width
    for (int x = 0; x < 4; x++) begin
      mem_a[x] = 8'hFF;
      mem_b[x] = 8'hFF;
    end
    clear_q();
    pulse_start(s);
    wait_done("t3", 1'b0, s, 1'b0);
    check_result("t3");
`ifdef MATMUL_SATURATE_EN
    if (wq_data.size() > 0) chk("t3_fmt", wq_data[0], 255);
`else
    if (wq_data.size() > 0) chk("t3_fmt", wq_data[0], 2);
`endif
    $display("t3 full scale: first R=%0d", (wq_data.size() > 0) ? wq_data[0] : -1);

    // 4: start re-pulsed while busy must be ignored
    load_random();
    clear_q();
    wbase = n_writes;
    pulse_start(s);
    wait_done("t4", 1'b1, s, 1'b1);
    check_result("t4");
    repeat (3) @(negedge clk);
    chk("t4_nwr_total", n_writes - wbase, M * N);
    chk("t4_idle", int'(busy), 0);
    $display("t4 start ignored while busy: writes=%0d", n_writes - wbase);

    // 5: reset in the cycle after the 2nd write
    load_random();
    clear_q();
    pulse_start(s);
    wcnt = 0;
    for (int n = 0; n < 100 && wcnt < 2; n++) begin
      @(negedge clk);
      if (r_write) wcnt++;
    end
    chk("t5_two_writes", wcnt, 2);
    @(negedge clk);
    rst = 1'b0;
    wbase = n_writes;
    @(negedge clk);
    chk_quiet("t5_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_nofurther", n_writes - wbase, 0);
    chk_quiet("t5_after");
    load_random();
    clear_q();
    pulse_start(s);
    wait_done("t5b", 1'b0, s, 1'b1);
    check_result("t5b");
    $display("t5 mid-run reset: writes after reset=%0d", wq_addr.size());

    // 6: start held high gives back-to-back runs
    load_random();
    clear_q();
    wbase = n_writes;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    s = edge_cnt;
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      chk("t6a_seen", int'(seen), 1);
    end
    chk("t6a_lat", edge_cnt - s, LAT);
    check_result("t6a");
    load_random();
    clear_q();
    @(negedge clk);
    s2 = edge_cnt;
    chk("t6_done_drop", int'(done), 0);
    chk("t6_restart_busy", int'(busy), 1);
    start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      chk("t6b_seen", int'(seen), 1);
    end
    chk("t6b_lat", edge_cnt - s2, LAT);
    check_result("t6b");
    chk("t6_nwr_total", n_writes - wbase, 2 * M * N);
    $display("t6 back-to-back: writes=%0d", n_writes - wbase);

    // Extra random runs
    for (int r = 0; r < 3; r++) begin
      load_random();
      clear_q();
      pulse_start(s);
      wait_done($sformatf("rnd%0d", r), 1'b0, s, 1'b1);
      check_result($sformatf("rnd%0d", r));
      $display("rnd%0d: writes=%0d", r, wq_addr.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
